// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory read responder.
package memory_responder_pkg;

  // Fetch FSM: idle/accept, latency wait, one-cycle response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latency counter sized for the largest supported READ_LATENCY (4).
  localparam int unsigned LAT_CNT_W = $clog2(4) + 1;

  // Legal READ_LATENCY range is 1..4.
  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/memory_read_iface.sv
// Single-beat fetch port with snoop broadcast of each served word.
interface memory_read_iface #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  broadcast_valid;
  logic [ADDR_WIDTH-1:0] broadcast_addr;

  modport in (
    input  valid, addr,
    output ready, data, broadcast_valid, broadcast_addr
  );

  modport out (
    output valid, addr,
    input  ready, data, broadcast_valid, broadcast_addr
  );
endinterface

// File: rtl/memory_responder_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
// Contents are intentionally not reset so the program survives a reset.
module memory_responder_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds the last word read until the next read.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_read_responder.sv
// Responder for instruction fetches: reads the program RAM with a fixed
// latency, pulses ready with the data and broadcasts the served address.
module memory_read_responder
  import memory_responder_pkg::*;
#(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 2,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  memory_read_iface.in                 memory,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic                         busy,
  output logic [COUNTER_WIDTH-1:0]     served_reads
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("memory_read_responder: READ_LATENCY must be in 1..4");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [LAT_CNT_W-1:0]           r_lat_cnt;
  logic [LAT_CNT_W-1:0]           w_lat_cnt_next;
  logic [MEMORY_ADDR_WIDTH-1:0]   r_addr_q;
  logic [COUNTER_WIDTH-1:0]       r_served;
  logic                           w_start;
  logic                           w_wr_en;
  logic                           w_resp;
  logic [MEMORY_WIDTH-1:0]        w_ram_rdata;

  // State, latency counter and captured address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_addr_q  <= '0;
    end else begin
      r_state   <= w_next_state;
      r_lat_cnt <= w_lat_cnt_next;
      if (w_start) begin
        r_addr_q <= memory.addr;
      end
    end
  end

  // Next-state logic; host writes win over fetches in IDLE.
  always_comb begin
    w_next_state   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_start        = 1'b0;
    w_wr_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_valid && !rst) begin
          w_wr_en = 1'b1;
        end else if (memory.valid && !rst) begin
          w_start        = 1'b1;
          w_lat_cnt_next = LAT_LOAD;
          w_next_state   = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_lat_cnt_next = r_lat_cnt - 1'b1;
        if (r_lat_cnt <= LAT_CNT_W'(1)) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Served-read counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_served <= '0;
    end else if (w_resp && (r_served != '1)) begin
      r_served <= r_served + 1'b1;
    end
  end

  // The read is issued once at capture; no write can reach the RAM until
  // the FSM is back in IDLE, so the RAM output register still holds the
  // word for addr_q when RESP arrives, for any latency.
  memory_responder_ram #(
    .DATA_W (MEMORY_WIDTH),
    .ADDR_W (MEMORY_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_re    (w_start),
    .i_raddr (memory.addr),
    .o_rdata (w_ram_rdata)
  );

  assign w_resp                 = (r_state == RESP);
  assign memory.ready           = w_resp;
  assign memory.data            = w_resp ? w_ram_rdata : '0;
  assign memory.broadcast_valid = w_resp;
  assign memory.broadcast_addr  = w_resp ? r_addr_q : '0;
  assign wr_ready               = w_wr_en;
  assign busy                   = (r_state != IDLE);
  assign served_reads           = r_served;

  // Requester must hold addr stable while its request is outstanding.
  a_addr_stable : assert property (
    @(posedge clk) disable iff (rst)
    (memory.valid && (r_state != IDLE)) |-> (memory.addr == r_addr_q)
  );

endmodule
